// File: rtl/operand_sel_pipe.sv
// Operand-A source selector for the multicycle datapath, carried through a
// STAGES-deep pipeline with valid tracking, stall, flush and out-of-range flagging.
module operand_sel_pipe #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      N_SRC       = 4,
    parameter int unsigned      SEL_W       = 2,
    parameter int unsigned      STAGES      = 1,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SRC*WIDTH-1:0] src_flat,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   in_valid,
    input  logic                   hold,
    input  logic                   flush,
    input  logic                   err_clr,
    output logic [WIDTH-1:0]       out_data,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   out_valid,
    output logic                   out_err,
    output logic                   err_sticky
);

    localparam int unsigned     LAST    = STAGES - 1;
    localparam logic [SEL_W:0]  N_SRC_W = (SEL_W + 1)'(N_SRC);

    logic                   accept_c;
    logic                   oor_c;
    logic [WIDTH-1:0]       sel_data_c;

    logic [STAGES-1:0]      vld_q,    vld_d;
    logic [WIDTH-1:0]       data_q    [STAGES];
    logic [WIDTH-1:0]       data_d    [STAGES];
    logic [SEL_W-1:0]       tag_q     [STAGES];
    logic [SEL_W-1:0]       tag_d     [STAGES];
    logic [STAGES-1:0]      err_q,    err_d;
    logic                   sticky_q, sticky_d;
    logic                   out_vld_q, out_vld_d;

    // Source mux; an out-of-range select falls through to DEFAULT_VAL
    always_comb begin
        accept_c   = in_valid & ~hold & ~flush;
        oor_c      = ({1'b0, sel} >= N_SRC_W);
        sel_data_c = DEFAULT_VAL;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (!oor_c && sel == SEL_W'(i)) begin
                sel_data_c = src_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state: data/tag/err only move with a valid beat so the last beat stays readable
    always_comb begin
        vld_d     = vld_q;
        data_d    = data_q;
        tag_d     = tag_q;
        err_d     = err_q;
        sticky_d  = sticky_q;
        out_vld_d = 1'b0;

        if (flush) begin
            vld_d = '0;
        end else if (!hold) begin
            for (int k = 1; k < int'(STAGES); k++) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                    tag_d[k]  = tag_q[k-1];
                    err_d[k]  = err_q[k-1];
                end
            end
            vld_d[0] = accept_c;
            if (accept_c) begin
                data_d[0] = sel_data_c;
                tag_d[0]  = sel;
                err_d[0]  = oor_c;
            end
            // A beat parked in the last stage during a stall is not re-announced
            out_vld_d = vld_d[LAST];
        end

        if (flush || !hold) begin
            if (accept_c && oor_c) begin
                sticky_d = 1'b1;
            end else if (err_clr) begin
                sticky_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q     <= '0;
            err_q     <= '0;
            sticky_q  <= 1'b0;
            out_vld_q <= 1'b0;
            for (int k = 0; k < int'(STAGES); k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            vld_q     <= vld_d;
            err_q     <= err_d;
            sticky_q  <= sticky_d;
            out_vld_q <= out_vld_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
        end
    end

    assign out_data   = data_q[LAST];
    assign out_sel    = tag_q[LAST];
    assign out_err    = err_q[LAST];
    assign out_valid  = out_vld_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Scoreboard bench for operand_sel_pipe: a 1-stage and a 3-stage instance share stimulus.
module tb_operand_sel_pipe;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  sel;
        logic        err;
        logic [2:0]  age;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] src_flat;
    logic [1:0]  sel;
    logic        in_valid, hold, flush, err_clr;

    logic [31:0] od1, od3;
    logic [1:0]  os1, os3;
    logic        ov1, ov3, oe1, oe3, es1, es3;

    int total = 0;
    int bad   = 0;

    beat_t q1[$];
    beat_t q3[$];
    beat_t last1, last3;
    logic  sticky_m;

    always #5 clk = ~clk;

    operand_sel_pipe #(.WIDTH(32), .N_SRC(3), .SEL_W(2), .STAGES(1), .DEFAULT_VAL(32'h0)) u_dut_s1 (
        .clk(clk), .reset(reset), .src_flat(src_flat), .sel(sel), .in_valid(in_valid),
        .hold(hold), .flush(flush), .err_clr(err_clr),
        .out_data(od1), .out_sel(os1), .out_valid(ov1), .out_err(oe1), .err_sticky(es1));

    operand_sel_pipe #(.WIDTH(32), .N_SRC(3), .SEL_W(2), .STAGES(3), .DEFAULT_VAL(32'h0)) u_dut_s3 (
        .clk(clk), .reset(reset), .src_flat(src_flat), .sel(sel), .in_valid(in_valid),
        .hold(hold), .flush(flush), .err_clr(err_clr),
        .out_data(od3), .out_sel(os3), .out_valid(ov3), .out_err(oe3), .err_sticky(es3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] src_of(input logic [1:0] s);
        case (s)
            2'd0:    return src_flat[31:0];
            2'd1:    return src_flat[63:32];
            2'd2:    return src_flat[95:64];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        q1.delete();
        q3.delete();
        last1    = '0;
        last3    = '0;
        sticky_m = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_od1"}, od1, 0); check({tag, "_os1"}, 32'(os1), 0);
        check({tag, "_ov1"}, 32'(ov1), 0); check({tag, "_oe1"}, 32'(oe1), 0);
        check({tag, "_es1"}, 32'(es1), 0);
        check({tag, "_od3"}, od3, 0); check({tag, "_os3"}, 32'(os3), 0);
        check({tag, "_ov3"}, 32'(ov3), 0); check({tag, "_oe3"}, 32'(oe3), 0);
        check({tag, "_es3"}, 32'(es3), 0);
    endtask

    // One clock: predict from the inputs as driven, then compare both instances
    task automatic cyc();
        logic  acc, adv, exp1, exp3;
        beat_t b;
        acc    = in_valid && !hold && !flush;
        b.sel  = sel;
        b.err  = (sel >= 2'd3);
        b.data = src_of(sel);
        b.age  = 3'd0;
        @(posedge clk);
        adv = 1'b0;
        if (flush) begin
            q1.delete();
            q3.delete();
        end else if (!hold) begin
            adv = 1'b1;
            foreach (q1[i]) q1[i].age++;
            foreach (q3[i]) q3[i].age++;
            if (acc) begin
                q1.push_back(b);
                q3.push_back(b);
            end
        end
        if (flush || !hold) begin
            if (acc && b.err) sticky_m = 1'b1;
            else if (err_clr) sticky_m = 1'b0;
        end
        #1;
        exp1 = adv && q1.size() > 0 && q1[0].age == 3'd0;
        exp3 = adv && q3.size() > 0 && q3[0].age == 3'd2;
        if (exp1) last1 = q1.pop_front();
        if (exp3) last3 = q3.pop_front();
        check("ov1", 32'(ov1), 32'(exp1));
        check("od1", od1, last1.data);
        check("os1", 32'(os1), 32'(last1.sel));
        check("oe1", 32'(oe1), 32'(last1.err));
        check("es1", 32'(es1), 32'(sticky_m));
        check("ov3", 32'(ov3), 32'(exp3));
        check("od3", od3, last3.data);
        check("os3", 32'(os3), 32'(last3.sel));
        check("oe3", 32'(oe3), 32'(last3.err));
        check("es3", 32'(es3), 32'(sticky_m));
    endtask

    task automatic beat(input logic [1:0] s);
        sel = s; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        reset    = 1'b1;
        src_flat = {32'h12345678, 32'hDEADBEEF, 32'h00400000};
        sel      = 2'd0;
        in_valid = 1'b0; hold = 1'b0; flush = 1'b0; err_clr = 1'b0;
        model_reset();
        #1;
        check_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero("rst_rel");

        // Single select through the 1-stage instance
        beat(2'd1);
        check("s1_data", od1, 32'hDEADBEEF);
        check("s1_vld", 32'(ov1), 1);
        cyc();
        check("s1_vld_pulse", 32'(ov1), 0);
        check("s1_data_held", od1, 32'hDEADBEEF);
        idle(2);

        // Out-of-range select, sticky set/clear, set beats clear
        beat(2'd3);
        check("oor_data", od1, 32'h0);
        check("oor_err", 32'(oe1), 1);
        check("oor_sticky", 32'(es1), 1);
        idle(3);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        check("clr_sticky", 32'(es1), 0);
        err_clr = 1'b1; beat(2'd3); err_clr = 1'b0;
        check("set_wins", 32'(es1), 1);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        idle(3);

        // Back-to-back with a 2-cycle stall mid-stream
        beat(2'd0);
        beat(2'd1);
        hold = 1'b1; in_valid = 1'b1; sel = 2'd2;
        idle(2);
        hold = 1'b0;
        beat(2'd2);
        idle(4);
        check("b2b_last", od3, 32'h12345678);

        // Flush with hold: in-flight beats vanish, sticky untouched
        beat(2'd3);
        beat(2'd0);
        flush = 1'b1; hold = 1'b1;
        cyc();
        flush = 1'b0; hold = 1'b0;
        idle(4);
        check("flush_data", od3, 32'h12345678);
        check("flush_sticky", 32'(es3), 1);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;

        // Asynchronous reset with two beats in flight
        beat(2'd1);
        beat(2'd0);
        #2;
        reset = 1'b1;
        #1;
        check_zero("rst_mid");
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        src_flat[95:64] = 32'hCAFEF00D;
        beat(2'd2);
        cyc();
        cyc();
        check("post_rst_vld", 32'(ov3), 1);
        check("post_rst_data", od3, 32'hCAFEF00D);
        idle(2);

        // Held request: only the release cycle accepts
        sel = 2'd1; in_valid = 1'b1; hold = 1'b1;
        idle(3);
        hold = 1'b0;
        cyc();
        in_valid = 1'b0;
        idle(4);

        check("drain_q1", 32'(q1.size()), 0);
        check("drain_q3", 32'(q3.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_sel_pipe.md
# operand_sel_pipe

Parametrised, registered successor to the datapath's 3-input ALU operand-A selector. It picks one of N_SRC WIDTH-bit sources (PC, MDR, A, and further sources such as shift amount or a constant) and carries the result through a STAGES-deep pipeline with valid tracking, stall (hold) and flush. Out-of-range selects are caught and flagged instead of being left undefined. The block sits between the register/PC/MDR outputs and the ALU input in the multicycle datapath, driven by the control FSM.

## Interface
- WIDTH, 32, data width of each source and of the output
- N_SRC, 4, number of sources (2..16)
- SEL_W, 2, select width; must satisfy 2^SEL_W >= N_SRC
- STAGES, 1, pipeline depth in register stages (1..4)
- DEFAULT_VAL, 0, WIDTH-bit value output for an out-of-range select
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- src_flat  in  N_SRC*WIDTH  source i occupies bits [i*WIDTH +: WIDTH]; source 0 = PC, 1 = MDR, 2 = A
- sel  in  SEL_W  source select, sampled with in_valid
- in_valid  in  1  a select/data beat is presented this cycle
- hold  in  1  stall: freeze every stage, ignore inputs
- flush  in  1  invalidate every stage
- err_clr  in  1  clear the sticky error flag
- out_data  out  WIDTH  selected operand after STAGES cycles
- out_sel  out  SEL_W  select value that produced out_data
- out_valid  out  1  out_data/out_sel are a new valid beat this cycle
- out_err  out  1  the current out_data came from an out-of-range select
- err_sticky  out  1  set by any accepted out-of-range select; held until err_clr

## Operation
- Accept: a beat is accepted when in_valid=1, hold=0 and flush=0.
- On accept, stage 0 loads data=src[sel], the select tag=sel, err=0, valid=1.
- Out-of-range select (sel >= N_SRC): stage 0 loads data=DEFAULT_VAL, tag=sel, err=1, valid=1.
- Stage k (k>=1) loads data/tag/err from stage k-1 only when stage k-1 is valid; its valid bit always copies stage k-1 valid.
- With hold=0 and no accept, stage 0 valid=0 and its data/tag/err keep their values.
- Result: data, tag and err hold the last valid beat between beats, so the FSM can read the operand later without recapture.
- hold=1 and flush=0: every register (valid, data, tag, err, sticky) holds its value; in_valid is ignored and the producer must re-present the beat.
- flush=1: all valid bits clear next edge; data/tag/err are retained; in_valid is ignored; flush has priority over hold.
- Outputs come from the last stage: out_data, out_sel, out_err, out_valid.
- err_sticky sets on the edge that accepts an out-of-range beat and clears on err_clr=1; if set and clear happen in the same cycle, set wins. err_sticky is not affected by flush.
- Widths: there is no arithmetic. Select comparison is unsigned over SEL_W bits. DEFAULT_VAL is truncated or zero-extended to WIDTH.

## Timing
- Reset (asynchronous, immediate): all valid bits 0, all data 0, tags 0, err bits 0, err_sticky 0. So out_data=0, out_sel=0, out_valid=0, out_err=0, err_sticky=0.
- Reset mid-pipeline discards in-flight beats; the first beat after reset deasserts is accepted normally.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES-1; STAGES=1 means visible the cycle after acceptance.
- Each hold cycle adds exactly one cycle to the latency of every in-flight beat; no beat is lost or duplicated.
- Throughput: one beat per cycle with hold=0; out_valid is a single-cycle pulse per beat.
- Sources are sampled only at the accepting edge; later source changes do not affect in-flight beats.

## Test plan
- STAGES=1, N_SRC=3, src0=0x00400000, src1=0xDEADBEEF, src2=0x12345678; sel=1 with in_valid one cycle -> next cycle out_data=0xDEADBEEF, out_sel=1, out_valid=1 for exactly one cycle; out_data still 0xDEADBEEF with out_valid=0 afterwards.
- N_SRC=3, sel=3 accepted -> out_data=DEFAULT_VAL (0), out_err=1, err_sticky=1; err_clr then -> err_sticky=0; err_clr in the same cycle as a new sel=3 accept -> err_sticky stays 1.
- STAGES=3, back-to-back sels 0,1,2 -> outputs src0, src1, src2 on three consecutive cycles starting 3 edges after the first accept; hold=1 for 2 cycles mid-stream -> same order, gap of exactly 2 cycles, no duplicates.
- STAGES=3, two beats in flight, flush=1 with hold=1 -> no out_valid for those beats; out_data keeps the last pre-flush valid value; err_sticky unchanged.
- Reset asserted asynchronously between edges with 2 beats in flight -> all outputs 0 immediately; first post-reset beat (sel=2, A=0xCAFEF00D) emerges after STAGES edges.
- in_valid=1 with hold=1 for 3 cycles, then hold=0 -> exactly one beat accepted and one out_valid pulse.
